// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - control bit indices, opcodes and immediate formats for the decode stage
package dec_pkg;

    localparam int CTRL_REG_WE = 0;
    localparam int CTRL_MEM_RD = 2;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: imm_fmt = IMM_I;
            OP_STORE:                 imm_fmt = IMM_S;
            OP_BRANCH:                imm_fmt = IMM_B;
            OP_LUI, OP_AUIPC:         imm_fmt = IMM_U;
            OP_JAL:                   imm_fmt = IMM_J;
            default:                  imm_fmt = IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_pl_if.sv
// rtl/decode_stage_pl_if.sv - decode inputs, writeback port and ID/EX outputs of the decode stage
interface decode_stage_pl_if #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int CTRL_W = 10
);
    logic [31:0]     instr_d;
    logic [XLEN-1:0] pc_d;
    logic            valid_d;
    logic [CTRL_W-1:0] ctrl_d;
    logic            stall;
    logic            flush;
    logic            wb_we;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            valid_ex;
    logic [CTRL_W-1:0] ctrl_ex;
    logic [XLEN-1:0] d1_ex;
    logic [XLEN-1:0] d2_ex;
    logic [XLEN-1:0] imm_ex;
    logic [XLEN-1:0] pc_ex;
    logic [AW-1:0]   rs1_ex;
    logic [AW-1:0]   rs2_ex;
    logic [AW-1:0]   rd_ex;
    logic            load_use_stall;

    modport master (
        output instr_d, pc_d, valid_d, ctrl_d, stall, flush, wb_we, wb_addr, wb_data,
        input  valid_ex, ctrl_ex, d1_ex, d2_ex, imm_ex, pc_ex, rs1_ex, rs2_ex, rd_ex,
               load_use_stall
    );

    modport slave (
        input  instr_d, pc_d, valid_d, ctrl_d, stall, flush, wb_we, wb_addr, wb_data,
        output valid_ex, ctrl_ex, d1_ex, d2_ex, imm_ex, pc_ex, rs1_ex, rs2_ex, rd_ex,
               load_use_stall
    );
endinterface

// File: rtl/dec_regfile.sv
// rtl/dec_regfile.sv - 2R1W register file; REGFILE_BYPASS_EN forwards same-cycle writes to reads
module dec_regfile #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);
    localparam int NREGS = 2 ** AW;

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
`ifdef REGFILE_BYPASS_EN
        if (we && (waddr == raddr1)) rdata1 = wdata;
        if (we && (waddr == raddr2)) rdata2 = wdata;
`endif
        // x0 override comes last so a bypassed write to x0 can never leak out
        if (raddr1 == '0) rdata1 = '0;
        if (raddr2 == '0) rdata2 = '0;
    end

endmodule

// File: rtl/decode_stage_pl.sv
// rtl/decode_stage_pl.sv - decode stage with immediate generation, load-use bubble and ID/EX register
module decode_stage_pl
    import dec_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int CTRL_W = 10
) (
    input logic               clk,
    input logic               rst,
    decode_stage_pl_if.slave  bus
);
    logic [31:0]       instr;
    logic [AW-1:0]     rs1, rs2, rd;
    logic [XLEN-1:0]   rdata1, rdata2;
    logic [31:0]       imm32;
    logic [XLEN-1:0]   imm;
    logic              hazard;

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [XLEN-1:0]   d1_q, d2_q, imm_q, pc_q;
    logic [AW-1:0]     rs1_q, rs2_q, rd_q;

    assign instr = bus.instr_d;
    assign rs1   = instr[15 +: AW];
    assign rs2   = instr[20 +: AW];
    assign rd    = instr[7 +: AW];

    dec_regfile #(.XLEN(XLEN), .AW(AW)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (bus.wb_we),
        .waddr  (bus.wb_addr),
        .wdata  (bus.wb_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    always_comb begin
        imm32 = '0;
        case (imm_fmt(instr[6:0]))
            IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm32 = {instr[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // sign-extends when XLEN > 32, truncates when narrower
    assign imm = XLEN'($signed(imm32));

    assign hazard = valid_q & ctrl_q[CTRL_MEM_RD] & (rd_q != '0) & bus.valid_d &
                    ((rd_q == rs1) | (rd_q == rs2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
        end else if (bus.flush || (!bus.stall && hazard)) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
        end else if (!bus.stall) begin
            valid_q <= bus.valid_d;
            ctrl_q  <= bus.valid_d ? bus.ctrl_d : '0;
            d1_q    <= rdata1;
            d2_q    <= rdata2;
            imm_q   <= imm;
            pc_q    <= bus.pc_d;
            rs1_q   <= rs1;
            rs2_q   <= rs2;
            rd_q    <= rd;
        end
    end

    assign bus.valid_ex       = valid_q;
    assign bus.ctrl_ex        = ctrl_q;
    assign bus.d1_ex          = d1_q;
    assign bus.d2_ex          = d2_q;
    assign bus.imm_ex         = imm_q;
    assign bus.pc_ex          = pc_q;
    assign bus.rs1_ex         = rs1_q;
    assign bus.rs2_ex         = rs2_q;
    assign bus.rd_ex          = rd_q;
    assign bus.load_use_stall = hazard;

endmodule

// File: tb/tb_decode_stage_pl.sv
// tb/tb_decode_stage_pl.sv - directed scoreboard bench for decode_stage_pl (REGFILE_BYPASS_EN aware)
module tb_decode_stage_pl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    decode_stage_pl_if #(.XLEN(32), .AW(5), .CTRL_W(10)) bus ();

    decode_stage_pl #(.XLEN(32), .AW(5), .CTRL_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        valid;
        logic [9:0]  ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] I_ADDI_M1 = 32'hFFF00093;
    localparam logic [31:0] I_JAL     = 32'h00C0006F;
    localparam logic [31:0] I_LW_X5   = 32'h00012283;
    localparam logic [31:0] I_ADD_X6  = 32'h00128333;
    localparam logic [31:0] I_SW_M4   = 32'hFE102E23;
    localparam logic [31:0] I_ADDI_X3 = 32'h00018213;
    localparam logic [9:0]  C_LOAD    = 10'h005;
    localparam logic [9:0]  C_ALU     = 10'h001;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic [9:0] c, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] imm,
                                input logic [31:0] pc, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd);
        exp_t e;
        e.valid = v; e.ctrl = c; e.d1 = d1; e.d2 = d2; e.imm = imm;
        e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        return e;
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic v, input logic [9:0] c);
        bus.instr_d = instr;
        bus.pc_d    = pc;
        bus.valid_d = v;
        bus.ctrl_d  = c;
    endtask

    task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.wb_we   = we;
        bus.wb_addr = a;
        bus.wb_data = d;
    endtask

    task automatic step(input string tag, input exp_t e);
        exp_t g;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk({tag, ".valid"}, 32'(bus.valid_ex), 32'(g.valid));
        chk({tag, ".ctrl"},  32'(bus.ctrl_ex),  32'(g.ctrl));
        chk({tag, ".d1"},    bus.d1_ex,         g.d1);
        chk({tag, ".d2"},    bus.d2_ex,         g.d2);
        chk({tag, ".imm"},   bus.imm_ex,        g.imm);
        chk({tag, ".pc"},    bus.pc_ex,         g.pc);
        chk({tag, ".rs1"},   32'(bus.rs1_ex),   32'(g.rs1));
        chk({tag, ".rs2"},   32'(bus.rs2_ex),   32'(g.rs2));
        chk({tag, ".rd"},    32'(bus.rd_ex),    32'(g.rd));
    endtask

    exp_t bubble;
    exp_t lw_e;
    exp_t add_e;

    initial begin
        bubble = mk(1'b0, 10'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        lw_e   = mk(1'b1, C_LOAD, 32'h0, 32'h0, 32'h0, 32'h80, 5'd2, 5'd0, 5'd5);
        add_e  = mk(1'b1, C_ALU, 32'h55, 32'h11, 32'h0, 32'h84, 5'd5, 5'd1, 5'd6);

        drive(32'h0, 32'h0, 1'b0, 10'h0);
        wb(1'b0, 5'd0, 32'h0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 32'(bus.valid_ex), 32'h0);
        chk("rst.lus",   32'(bus.load_use_stall), 32'h0);
        rst = 1'b1;

        // populate x1 so the later reset has something to clear
        wb(1'b1, 5'd1, 32'h11);
        step("wr_x1", bubble);
        wb(1'b0, 5'd0, 32'h0);
        drive(I_ADDI_M1, 32'h40, 1'b1, C_ALU);
        step("pre_rst", mk(1'b1, C_ALU, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h40, 5'd0, 5'd31, 5'd1));

        #2 rst = 1'b0;
        #1;
        chk("arst.valid", 32'(bus.valid_ex), 32'h0);
        chk("arst.ctrl",  32'(bus.ctrl_ex),  32'h0);
        chk("arst.imm",   bus.imm_ex,        32'h0);
        chk("arst.pc",    bus.pc_ex,         32'h0);
        chk("arst.rd",    32'(bus.rd_ex),    32'h0);
        chk("arst.lus",   32'(bus.load_use_stall), 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 1; i < 32; i++) begin
            logic [4:0] r;
            r = 5'(i);
            drive({7'b0, r, r, 3'b0, r, 7'h33}, 32'h0, 1'b1, 10'h0);
            step("rd_clear", mk(1'b1, 10'h0, 32'h0, 32'h0, 32'h0, 32'h0, r, r, r));
        end

        drive(32'h0, 32'h0, 1'b0, 10'h0);
        wb(1'b1, 5'd1, 32'h11);
        step("wr_x1b", bubble);
        wb(1'b1, 5'd5, 32'h55);
        step("wr_x5", bubble);
        wb(1'b1, 5'd3, 32'h33);
        step("wr_x3", bubble);
        wb(1'b0, 5'd0, 32'h0);

        drive(I_ADDI_M1, 32'h100, 1'b1, C_ALU);
        step("imm_i", mk(1'b1, C_ALU, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h100, 5'd0, 5'd31, 5'd1));
        drive(I_JAL, 32'h104, 1'b1, C_ALU);
        step("imm_j", mk(1'b1, C_ALU, 32'h0, 32'h0, 32'h0000000C, 32'h104, 5'd0, 5'd12, 5'd0));
        drive(I_SW_M4, 32'h108, 1'b1, 10'h0);
        step("imm_s", mk(1'b1, 10'h0, 32'h0, 32'h11, 32'hFFFFFFFC, 32'h108, 5'd0, 5'd1, 5'd28));

        drive(I_LW_X5, 32'h80, 1'b1, C_LOAD);
        step("lu_lw", lw_e);
        drive(I_ADD_X6, 32'h84, 1'b1, C_ALU);
        #1 chk("lu.stall_hi", 32'(bus.load_use_stall), 32'h1);
        step("lu_bubble", bubble);
        chk("lu.stall_lo", 32'(bus.load_use_stall), 32'h0);
        step("lu_add", add_e);

        drive(I_ADDI_M1, 32'h90, 1'b1, C_ALU);
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        step("flush_stall", bubble);
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        drive(I_LW_X5, 32'h80, 1'b1, C_LOAD);
        step("st_lw", lw_e);
        drive(I_ADD_X6, 32'h84, 1'b1, C_ALU);
        bus.stall = 1'b1;
        #1 chk("st.lus", 32'(bus.load_use_stall), 32'h1);
        step("st_hold", lw_e);
        bus.stall = 1'b0;
        step("st_bubble", bubble);
        step("st_add", add_e);

        drive(I_ADDI_X3, 32'hC0, 1'b1, C_ALU);
        wb(1'b1, 5'd3, 32'hA5A5A5A5);
`ifdef REGFILE_BYPASS_EN
        step("wb_same", mk(1'b1, C_ALU, 32'hA5A5A5A5, 32'h0, 32'h0, 32'hC0, 5'd3, 5'd0, 5'd4));
`else
        step("wb_same", mk(1'b1, C_ALU, 32'h33, 32'h0, 32'h0, 32'hC0, 5'd3, 5'd0, 5'd4));
`endif
        wb(1'b0, 5'd0, 32'h0);
        step("wb_next", mk(1'b1, C_ALU, 32'hA5A5A5A5, 32'h0, 32'h0, 32'hC0, 5'd3, 5'd0, 5'd4));

        drive(I_ADDI_M1, 32'hC4, 1'b1, C_ALU);
        wb(1'b1, 5'd0, 32'hDEADBEEF);
        step("x0_same", mk(1'b1, C_ALU, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hC4, 5'd0, 5'd31, 5'd1));
        wb(1'b0, 5'd0, 32'h0);
        step("x0_next", mk(1'b1, C_ALU, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hC4, 5'd0, 5'd31, 5'd1));

        drive(32'h0, 32'h200, 1'b0, 10'h3FF);
        step("bubble_in", mk(1'b0, 10'h0, 32'h0, 32'h0, 32'h0, 32'h200, 5'd0, 5'd0, 5'd0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
